bfly_stage_pipe: RTL and testbench
==================================

BFLY_STAGE_PIPE -- requirements
Module: bfly_stage_pipe

Interface
REQ-001 Parameter N, default 16, SHALL set the lane count (complex pairs per beat).
REQ-002 Parameter IN_BIT, default 9, SHALL set the signed input width per I/Q component.
REQ-003 Parameter BLK_LEN, default 16, SHALL set the beats per block; legal range 2..256, even.
REQ-004 Parameter SWITCH, default 8, SHALL set the first block index using W=-j in AUTO mode; legal range 1..BLK_LEN-1.
REQ-005 Localparams SHALL be OUT_BIT = IN_BIT+1 and CNT_W = $clog2(BLK_LEN).
REQ-006 Ports, clock and reset first. Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- din_valid  in  1  input beat valid.
- din_ready  out  1  input beat accepted when din_valid && din_ready.
- din1_i, din1_q, din2_i, din2_q  in  signed [IN_BIT-1:0] [0:N-1]  butterfly operands a, b.
- tw_mode  in  2  bfly_pkg::tw_mode_t twiddle select, sampled per beat.
- scale_en  in  1  divide results by 2, sampled per beat.
- blk_clr  in  1  restart block index.
- dout_valid  out  1  output beat valid.
- dout_ready  in  1  downstream accepts when dout_valid && dout_ready.
- dout1_i, dout1_q, dout2_i, dout2_q  out  signed [OUT_BIT-1:0] [0:N-1]  results.
- dout_idx  out  CNT_W  block index of the output beat.
- dout_last  out  1  output beat has index BLK_LEN-1.

Function
REQ-007 The block SHALL compute per lane x = a+b, y = a-b, then dout1 = x and dout2 = y*W, with W chosen per REQ-008.
REQ-008 tw_mode SHALL select W: AUTO (00) gives W=1 when idx<SWITCH, else W=-j; ONE (01) gives W=1; NEG_J (10) gives W=-j; POS_J (11) gives W=+j.
REQ-009 W=-j SHALL map (yi,yq) to (yq,-yi); W=+j SHALL map (yi,yq) to (-yq,yi).
REQ-010 All sums SHALL be computed at OUT_BIT with sign extension, with no overflow possible.
REQ-011 When scale_en=1, each output component SHALL be (v+1)>>>1, computed at OUT_BIT+1 and then truncated to OUT_BIT.
REQ-012 The datapath SHALL use one output register stage: an accepted beat appears on the outputs the next cycle with dout_valid=1.
REQ-013 din_ready SHALL equal !dout_valid || dout_ready, combinationally.
REQ-014 While dout_valid && !dout_ready, all outputs SHALL hold stable.
REQ-015 If dout_valid && dout_ready and no beat is accepted, dout_valid SHALL fall next cycle.
REQ-016 The block index counter SHALL advance only on an accepted beat and wrap from BLK_LEN-1 to 0.
REQ-017 The counter SHALL hold while idle; a gap in din_valid SHALL NOT reset it.
REQ-018 blk_clr without an accepted beat SHALL set the counter to 0.
REQ-019 blk_clr with an accepted beat SHALL process that beat with idx 0 and set the counter to 1.
REQ-020 dout_idx and dout_last SHALL be registered alongside the data and belong to the same beat.

Reset
REQ-021 rst=1 SHALL force dout_valid=0, counter=0, dout_idx=0, dout_last=0, and all data outputs to 0 on the next edge.
REQ-022 rst SHALL override every other input, including blk_clr and an accepted beat.
REQ-023 Mid-block reset SHALL discard the in-flight beat; the first beat after reset SHALL carry idx 0.

Structure
REQ-024 Package bfly_pkg SHALL hold tw_mode_t (AUTO, ONE, NEG_J, POS_J) and the twiddle-rotate/scale functions.
REQ-025 A combinational sub-module bfly_lane (one complex butterfly, twiddle and scale) SHALL be instantiated N times by generate.
REQ-026 Parameter legality (REQ-003, REQ-004) SHALL be checked by elaboration-time assertions.

Verification
REQ-027 Reset and idle: rst for 2 cycles -> dout_valid=0, all outputs 0, din_ready=1.
REQ-028 AUTO sequence: 16 beats back-to-back with lane0 a=(100,-50), b=(20,30).
- idx 0..7 -> dout1=(120,-20), dout2=(80,-80).
- idx 8..15 -> dout2=(-80,-80).
- dout_last=1 only on idx 15; next beat has idx 0.
REQ-029 Extremes and scale: a=(255,-256), b=(255,-256), ONE mode -> dout1=(510,-512), dout2=(0,0); the same beat with scale_en=1 -> dout1=(255,-256).
REQ-030 Backpressure: dout_ready=0 for 3 cycles mid-stream -> outputs stable, din_ready=0, no beat lost or duplicated, indices contiguous.
REQ-031 blk_clr at idx 5 with a concurrent beat -> that beat carries idx 0, the following beat idx 1.
REQ-032 POS_J mode with a=(10,4), b=(3,1) -> dout2=(-3,7); rst asserted mid-block -> the next beat carries idx 0.

Source files
------------

// File: rtl/bfly_pkg.sv
// Shared types and arithmetic helpers for the pipelined radix-2 butterfly stage.
package bfly_pkg;

    typedef enum logic [1:0] {
        AUTO  = 2'b00,
        ONE   = 2'b01,
        NEG_J = 2'b10,
        POS_J = 2'b11
    } tw_mode_t;

    typedef struct packed {
        logic signed [31:0] re;
        logic signed [31:0] im;
    } cplx_t;

    // AUTO is resolved by the caller before reaching here, so it behaves as W=1.
    function automatic cplx_t tw_rotate(input tw_mode_t m, input cplx_t y);
        cplx_t r;
        r = y;
        case (m)
            NEG_J: begin
                r.re = y.im;
                r.im = -y.re;
            end
            POS_J: begin
                r.re = -y.im;
                r.im = y.re;
            end
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic signed [31:0] scale_half(input logic signed [31:0] v,
                                                      input logic en);
        return en ? ((v + 32'sd1) >>> 1) : v;
    endfunction

endpackage

// File: rtl/bfly_lane.sv
// One combinational complex butterfly lane: sum/difference, twiddle on the difference, optional halving.
module bfly_lane
    import bfly_pkg::*;
#(
    parameter int IN_BIT  = 9,
    parameter int OUT_BIT = IN_BIT + 1
) (
    input  logic signed [IN_BIT-1:0]  a_re_i,
    input  logic signed [IN_BIT-1:0]  a_im_i,
    input  logic signed [IN_BIT-1:0]  b_re_i,
    input  logic signed [IN_BIT-1:0]  b_im_i,
    input  tw_mode_t                  tw_i,
    input  logic                      scale_en_i,
    output logic signed [OUT_BIT-1:0] x_re_o,
    output logic signed [OUT_BIT-1:0] x_im_o,
    output logic signed [OUT_BIT-1:0] y_re_o,
    output logic signed [OUT_BIT-1:0] y_im_o
);

    logic signed [OUT_BIT-1:0] x_re, x_im, y_re, y_im;
    cplx_t y_in, y_rot;

    assign x_re = OUT_BIT'(a_re_i) + OUT_BIT'(b_re_i);
    assign x_im = OUT_BIT'(a_im_i) + OUT_BIT'(b_im_i);
    assign y_re = OUT_BIT'(a_re_i) - OUT_BIT'(b_re_i);
    assign y_im = OUT_BIT'(a_im_i) - OUT_BIT'(b_im_i);

    always_comb begin
        y_in.re = 32'(y_re);
        y_in.im = 32'(y_im);
        y_rot   = tw_rotate(tw_i, y_in);
    end

    assign x_re_o = OUT_BIT'(scale_half(32'(x_re), scale_en_i));
    assign x_im_o = OUT_BIT'(scale_half(32'(x_im), scale_en_i));
    assign y_re_o = OUT_BIT'(scale_half(y_rot.re, scale_en_i));
    assign y_im_o = OUT_BIT'(scale_half(y_rot.im, scale_en_i));

endmodule

// File: rtl/bfly_stage_pipe.sv
// N-lane butterfly stage with one registered output slot, ready/valid handshake and block index tracking.
module bfly_stage_pipe
    import bfly_pkg::*;
#(
    parameter  int N       = 16,
    parameter  int IN_BIT  = 9,
    parameter  int BLK_LEN = 16,
    parameter  int SWITCH  = 8,
    localparam int OUT_BIT = IN_BIT + 1,
    localparam int CNT_W   = $clog2(BLK_LEN)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      din_valid,
    output logic                      din_ready,
    input  logic signed [IN_BIT-1:0]  din1_i [0:N-1],
    input  logic signed [IN_BIT-1:0]  din1_q [0:N-1],
    input  logic signed [IN_BIT-1:0]  din2_i [0:N-1],
    input  logic signed [IN_BIT-1:0]  din2_q [0:N-1],
    input  tw_mode_t                  tw_mode,
    input  logic                      scale_en,
    input  logic                      blk_clr,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic signed [OUT_BIT-1:0] dout1_i [0:N-1],
    output logic signed [OUT_BIT-1:0] dout1_q [0:N-1],
    output logic signed [OUT_BIT-1:0] dout2_i [0:N-1],
    output logic signed [OUT_BIT-1:0] dout2_q [0:N-1],
    output logic [CNT_W-1:0]          dout_idx,
    output logic                      dout_last
);

    if (BLK_LEN < 2 || BLK_LEN > 256 || (BLK_LEN % 2) != 0) begin : g_bad_blk_len
        $error("bfly_stage_pipe: BLK_LEN must be even and within 2..256");
    end
    if (SWITCH < 1 || SWITCH > BLK_LEN - 1) begin : g_bad_switch
        $error("bfly_stage_pipe: SWITCH must be within 1..BLK_LEN-1");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d, idx_cur, idx_q;
    logic             accept, last_cur, valid_q, last_q;
    tw_mode_t         tw_eff;

    logic signed [OUT_BIT-1:0] d1i_d [0:N-1], d1q_d [0:N-1], d2i_d [0:N-1], d2q_d [0:N-1];
    logic signed [OUT_BIT-1:0] d1i_q [0:N-1], d1q_q [0:N-1], d2i_q [0:N-1], d2q_q [0:N-1];

    assign din_ready = !valid_q || dout_ready;
    assign accept    = din_valid && din_ready;

    // A beat arriving with blk_clr is the first beat of a fresh block.
    always_comb begin
        idx_cur  = blk_clr ? '0 : cnt_q;
        last_cur = (idx_cur == CNT_W'(BLK_LEN - 1));
        tw_eff   = tw_mode;
        if (tw_mode == AUTO) begin
            tw_eff = (idx_cur < CNT_W'(SWITCH)) ? ONE : NEG_J;
        end
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = last_cur ? '0 : idx_cur + CNT_W'(1);
        end else if (blk_clr) begin
            cnt_d = '0;
        end
    end

    for (genvar l = 0; l < N; l++) begin : g_lane
        bfly_lane #(
            .IN_BIT (IN_BIT),
            .OUT_BIT(OUT_BIT)
        ) u_lane (
            .a_re_i    (din1_i[l]),
            .a_im_i    (din1_q[l]),
            .b_re_i    (din2_i[l]),
            .b_im_i    (din2_q[l]),
            .tw_i      (tw_eff),
            .scale_en_i(scale_en),
            .x_re_o    (d1i_d[l]),
            .x_im_o    (d1q_d[l]),
            .y_re_o    (d2i_d[l]),
            .y_im_o    (d2q_d[l])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            for (int l = 0; l < N; l++) begin
                d1i_q[l] <= '0;
                d1q_q[l] <= '0;
                d2i_q[l] <= '0;
                d2q_q[l] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                valid_q <= 1'b1;
                idx_q   <= idx_cur;
                last_q  <= last_cur;
                for (int l = 0; l < N; l++) begin
                    d1i_q[l] <= d1i_d[l];
                    d1q_q[l] <= d1q_d[l];
                    d2i_q[l] <= d2i_d[l];
                    d2q_q[l] <= d2q_d[l];
                end
            end else if (dout_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign dout_valid = valid_q;
    assign dout_idx   = idx_q;
    assign dout_last  = last_q;
    assign dout1_i    = d1i_q;
    assign dout1_q    = d1q_q;
    assign dout2_i    = d2i_q;
    assign dout2_q    = d2q_q;

endmodule

// File: tb/tb_bfly_stage_pipe.sv
// Scoreboard bench for bfly_stage_pipe with default parameters.
module tb_bfly_stage_pipe;
    import bfly_pkg::*;

    localparam int N = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic din_valid = 1'b0;
    logic din_ready;
    logic signed [8:0] din1_i [0:N-1];
    logic signed [8:0] din1_q [0:N-1];
    logic signed [8:0] din2_i [0:N-1];
    logic signed [8:0] din2_q [0:N-1];
    tw_mode_t tw_mode = AUTO;
    logic scale_en = 1'b0;
    logic blk_clr = 1'b0;
    logic dout_valid;
    logic dout_ready = 1'b1;
    logic signed [9:0] dout1_i [0:N-1];
    logic signed [9:0] dout1_q [0:N-1];
    logic signed [9:0] dout2_i [0:N-1];
    logic signed [9:0] dout2_q [0:N-1];
    logic [3:0] dout_idx;
    logic dout_last;

    typedef struct {
        int d1i[N];
        int d1q[N];
        int d2i[N];
        int d2q[N];
        int idx;
        bit last;
    } exp_t;

    exp_t sb[$];
    int   exp_cnt = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    bfly_stage_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .din1_i    (din1_i),
        .din1_q    (din1_q),
        .din2_i    (din2_i),
        .din2_q    (din2_q),
        .tw_mode   (tw_mode),
        .scale_en  (scale_en),
        .blk_clr   (blk_clr),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout1_i   (dout1_i),
        .dout1_q   (dout1_q),
        .dout2_i   (dout2_i),
        .dout2_q   (dout2_q),
        .dout_idx  (dout_idx),
        .dout_last (dout_last)
    );

    always #5 clk = ~clk;

    function automatic int rnd();
        return int'($urandom_range(511, 0)) - 256;
    endfunction

    function automatic int sc(input int v, input bit s);
        return s ? ((v + 1) >>> 1) : v;
    endfunction

    // One cycle: drive at negedge, retire the output beat if it transfers, model the accepted beat.
    task automatic drive_cycle(input bit v, input tw_mode_t m, input bit s, input bit clr,
                               input bit rdy, input int ai, input int aq, input int bi, input int bq);
        int   la_i[N], la_q[N], lb_i[N], lb_q[N];
        int   idx, yi, yq, wi, wq;
        bit   bad;
        tw_mode_t me;
        exp_t e;
        @(negedge clk);
        din_valid  = v;
        tw_mode    = m;
        scale_en   = s;
        blk_clr    = clr;
        dout_ready = rdy;
        for (int l = 0; l < N; l++) begin
            la_i[l] = (l == 0) ? ai : rnd();
            la_q[l] = (l == 0) ? aq : rnd();
            lb_i[l] = (l == 0) ? bi : rnd();
            lb_q[l] = (l == 0) ? bq : rnd();
            din1_i[l] = 9'(la_i[l]);
            din1_q[l] = 9'(la_q[l]);
            din2_i[l] = 9'(lb_i[l]);
            din2_q[l] = 9'(lb_q[l]);
        end
        #1;
        if (dout_valid && dout_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected_beat got idx %0d, required no beat", dout_idx);
            end else begin
                e = sb.pop_front();
                bad = (int'(dout_idx) !== e.idx) || (dout_last !== e.last);
                for (int l = 0; l < N; l++) begin
                    if (int'(dout1_i[l]) !== e.d1i[l] || int'(dout1_q[l]) !== e.d1q[l] ||
                        int'(dout2_i[l]) !== e.d2i[l] || int'(dout2_q[l]) !== e.d2q[l]) bad = 1;
                end
                if (bad) begin
                    n_bad++;
                    $display("FAIL sb_beat got idx=%0d last=%0b d1=(%0d,%0d) d2=(%0d,%0d), required idx=%0d last=%0b d1=(%0d,%0d) d2=(%0d,%0d)",
                             dout_idx, dout_last, dout1_i[0], dout1_q[0], dout2_i[0], dout2_q[0],
                             e.idx, e.last, e.d1i[0], e.d1q[0], e.d2i[0], e.d2q[0]);
                end
            end
        end
        if (din_valid && din_ready) begin
            idx = clr ? 0 : exp_cnt;
            me  = m;
            if (m == AUTO) me = (idx < 8) ? ONE : NEG_J;
            for (int l = 0; l < N; l++) begin
                yi = la_i[l] - lb_i[l];
                yq = la_q[l] - lb_q[l];
                wi = yi;
                wq = yq;
                if (me == NEG_J) begin wi = yq;  wq = -yi; end
                if (me == POS_J) begin wi = -yq; wq = yi;  end
                e.d1i[l] = sc(la_i[l] + lb_i[l], s);
                e.d1q[l] = sc(la_q[l] + lb_q[l], s);
                e.d2i[l] = sc(wi, s);
                e.d2q[l] = sc(wq, s);
            end
            e.idx  = idx;
            e.last = (idx == 15);
            sb.push_back(e);
            exp_cnt = (idx == 15) ? 0 : idx + 1;
        end else if (clr) begin
            exp_cnt = 0;
        end
    endtask

    // Reset is held with a valid beat and blk_clr present so it must win over both.
    task automatic do_reset(input int cyc);
        @(negedge clk);
        rst        = 1'b1;
        din_valid  = 1'b1;
        blk_clr    = 1'b1;
        dout_ready = 1'b1;
        tw_mode    = POS_J;
        repeat (cyc) @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        din_valid = 1'b0;
        blk_clr   = 1'b0;
        sb.delete();
        exp_cnt = 0;
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 8 && (sb.size() != 0 || dout_valid); k++)
            drive_cycle(0, ONE, 0, 0, 1, 0, 0, 0, 0);
        n_cmp++;
        if (sb.size() != 0 || dout_valid) begin
            n_bad++;
            $display("FAIL drain got %0d pending beats valid=%0b, required 0 pending", sb.size(), dout_valid);
        end
    endtask

    task automatic test_reset();
        bit nz;
        for (int l = 0; l < N; l++) begin
            din1_i[l] = '0; din1_q[l] = '0; din2_i[l] = '0; din2_q[l] = '0;
        end
        do_reset(2);
        n_cmp++;
        if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %0b, required 0", dout_valid); end
        n_cmp++;
        if (din_ready !== 1'b1) begin n_bad++; $display("FAIL rst_din_ready got %0b, required 1", din_ready); end
        n_cmp++;
        if (dout_idx !== 4'd0 || dout_last !== 1'b0) begin
            n_bad++; $display("FAIL rst_idx got idx=%0d last=%0b, required 0/0", dout_idx, dout_last);
        end
        nz = 0;
        for (int l = 0; l < N; l++)
            if (dout1_i[l] !== 10'sd0 || dout1_q[l] !== 10'sd0 || dout2_i[l] !== 10'sd0 || dout2_q[l] !== 10'sd0) nz = 1;
        n_cmp++;
        if (nz) begin n_bad++; $display("FAIL rst_data got nonzero lane data (lane0 d1i=%0d), required 0", dout1_i[0]); end
    endtask

    task automatic test_auto();
        int pi, pd2i;
        for (int k = 0; k <= 16; k++) begin
            drive_cycle(1, AUTO, 0, 0, 1, 100, -50, 20, 30);
            if (k >= 1) begin
                pi   = (k - 1) % 16;
                pd2i = (pi < 8) ? 80 : -80;
                n_cmp++;
                if (int'(dout_idx) !== pi || dout_last !== (pi == 15) || dout1_i[0] !== 10'sd120 ||
                    dout1_q[0] !== -10'sd20 || int'(dout2_i[0]) !== pd2i || dout2_q[0] !== -10'sd80) begin
                    n_bad++;
                    $display("FAIL auto_beat got idx=%0d last=%0b d1=(%0d,%0d) d2=(%0d,%0d), required idx=%0d last=%0b d1=(120,-20) d2=(%0d,-80)",
                             dout_idx, dout_last, dout1_i[0], dout1_q[0], dout2_i[0], dout2_q[0], pi, pi == 15, pd2i);
                end
            end
        end
        drain();
    endtask

    task automatic test_extremes();
        drive_cycle(1, ONE, 0, 0, 1, 255, -256, 255, -256);
        drive_cycle(1, ONE, 1, 0, 1, 255, -256, 255, -256);
        n_cmp++;
        if (dout1_i[0] !== 10'sd510 || dout1_q[0] !== -10'sd512 || dout2_i[0] !== 10'sd0 || dout2_q[0] !== 10'sd0) begin
            n_bad++;
            $display("FAIL extreme_raw got d1=(%0d,%0d) d2=(%0d,%0d), required (510,-512) (0,0)",
                     dout1_i[0], dout1_q[0], dout2_i[0], dout2_q[0]);
        end
        drive_cycle(0, ONE, 0, 0, 1, 0, 0, 0, 0);
        n_cmp++;
        if (dout1_i[0] !== 10'sd255 || dout1_q[0] !== -10'sd256 || dout2_i[0] !== 10'sd0 || dout2_q[0] !== 10'sd0) begin
            n_bad++;
            $display("FAIL extreme_scaled got d1=(%0d,%0d) d2=(%0d,%0d), required (255,-256) (0,0)",
                     dout1_i[0], dout1_q[0], dout2_i[0], dout2_q[0]);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic signed [9:0] s1i, s2q;
        logic [3:0] sidx;
        for (int k = 0; k < 12; k++) begin
            drive_cycle(1, AUTO, k[0], 0, !(k >= 5 && k <= 7), rnd(), rnd(), rnd(), rnd());
            if (k == 5) begin
                s1i = dout1_i[0]; s2q = dout2_q[0]; sidx = dout_idx;
            end
            if (k >= 5 && k <= 7) begin
                n_cmp++;
                if (din_ready !== 1'b0 || dout_valid !== 1'b1) begin
                    n_bad++; $display("FAIL stall_ready got din_ready=%0b valid=%0b, required 0/1", din_ready, dout_valid);
                end
            end
            if (k == 6 || k == 7) begin
                n_cmp++;
                if (dout1_i[0] !== s1i || dout2_q[0] !== s2q || dout_idx !== sidx) begin
                    n_bad++;
                    $display("FAIL stall_hold got d1i=%0d d2q=%0d idx=%0d, required %0d %0d %0d",
                             dout1_i[0], dout2_q[0], dout_idx, s1i, s2q, sidx);
                end
            end
        end
        drain();
    endtask

    task automatic test_blk_clr();
        do_reset(1);
        for (int k = 0; k < 5; k++) drive_cycle(1, ONE, 0, 0, 1, rnd(), rnd(), rnd(), rnd());
        drive_cycle(1, ONE, 0, 1, 1, rnd(), rnd(), rnd(), rnd());
        drive_cycle(1, AUTO, 0, 0, 1, rnd(), rnd(), rnd(), rnd());
        n_cmp++;
        if (dout_idx !== 4'd0) begin n_bad++; $display("FAIL clr_beat_idx got %0d, required 0", dout_idx); end
        drive_cycle(0, ONE, 0, 0, 1, 0, 0, 0, 0);
        n_cmp++;
        if (dout_idx !== 4'd1) begin n_bad++; $display("FAIL clr_next_idx got %0d, required 1", dout_idx); end
        drive_cycle(0, ONE, 0, 1, 1, 0, 0, 0, 0);
        drive_cycle(1, AUTO, 0, 0, 1, rnd(), rnd(), rnd(), rnd());
        drive_cycle(0, ONE, 0, 0, 1, 0, 0, 0, 0);
        n_cmp++;
        if (dout_idx !== 4'd0) begin n_bad++; $display("FAIL clr_idle_idx got %0d, required 0", dout_idx); end
        drain();
    endtask

    task automatic test_posj_rst();
        drive_cycle(1, POS_J, 0, 0, 1, 10, 4, 3, 1);
        drive_cycle(0, ONE, 0, 0, 1, 0, 0, 0, 0);
        n_cmp++;
        if (dout2_i[0] !== -10'sd3 || dout2_q[0] !== 10'sd7 || dout1_i[0] !== 10'sd13 || dout1_q[0] !== 10'sd5) begin
            n_bad++;
            $display("FAIL posj got d1=(%0d,%0d) d2=(%0d,%0d), required (13,5) (-3,7)",
                     dout1_i[0], dout1_q[0], dout2_i[0], dout2_q[0]);
        end
        for (int k = 0; k < 4; k++) drive_cycle(1, AUTO, 0, 0, 0, rnd(), rnd(), rnd(), rnd());
        do_reset(1);
        n_cmp++;
        if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got %0b, required 0", dout_valid); end
        drive_cycle(1, AUTO, 0, 0, 1, rnd(), rnd(), rnd(), rnd());
        drive_cycle(0, ONE, 0, 0, 1, 0, 0, 0, 0);
        n_cmp++;
        if (dout_valid !== 1'b1 || dout_idx !== 4'd0) begin
            n_bad++; $display("FAIL midrst_idx got valid=%0b idx=%0d, required 1/0", dout_valid, dout_idx);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_auto();
        test_extremes();
        test_backpressure();
        test_blk_clr();
        test_posj_rst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
